// File: rtl/execute_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : execute_pipe                                                    |
// | Brief    : single-issue execute stage (ALU, branch/jump resolve, opt. MUL) |
// |            MUL path enabled by defining EXECUTE_PIPE_MUL_EN.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module execute_pipe #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [3:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic            in_is_branch,
    input  logic            in_is_jal,
    input  logic            in_is_jalr,
    input  logic            in_is_mul,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int c_SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_a, w_b, w_alu, w_result, w_target, w_jalr_sum;
    logic [c_SHW-1:0] w_shamt;
    logic            w_taken, w_redirect, w_accept, w_slot_free, w_mul_start;

    logic            out_valid_q, redirect_valid_q, rw_q, mr_q, mw_q;
    logic [XLEN-1:0] result_q, store_q, redirect_pc_q;
    logic [4:0]      rd_q;

    assign w_slot_free = !out_valid_q || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_a         = in_use_pc  ? in_pc  : in_rs1;
    assign w_b         = in_use_imm ? in_imm : in_rs2;
    assign w_shamt     = w_b[c_SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (in_alu_op)
            4'd0: w_alu = w_a + w_b;
            4'd1: w_alu = w_a - w_b;
            4'd2: w_alu = w_a << w_shamt;
            4'd3: w_alu = XLEN'($signed(w_a) < $signed(w_b));
            4'd4: w_alu = XLEN'(w_a < w_b);
            4'd5: w_alu = w_a ^ w_b;
            4'd6: w_alu = w_a >> w_shamt;
            4'd7: w_alu = $unsigned($signed(w_a) >>> w_shamt);
            4'd8: w_alu = w_a | w_b;
            4'd9: w_alu = w_a & w_b;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (in_funct3)
            3'b000: w_taken = (in_rs1 == in_rs2);
            3'b001: w_taken = (in_rs1 != in_rs2);
            3'b100: w_taken = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101: w_taken = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110: w_taken = (in_rs1 <  in_rs2);
            3'b111: w_taken = (in_rs1 >= in_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum = in_rs1 + in_imm;
    assign w_target   = in_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : in_pc + in_imm;
    assign w_redirect = in_is_jal || in_is_jalr || (in_is_branch && w_taken);
    assign w_result   = (in_is_jal || in_is_jalr) ? in_pc + XLEN'(4) : w_alu;

`ifdef EXECUTE_PIPE_MUL_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_MUL   = 1'b1;
    localparam int         c_STEPS = XLEN / MUL_STEP;
    localparam int         c_CW    = $clog2(c_STEPS + 1);

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q, w_acc_step, mul_sd_q;
    logic [c_CW-1:0] cnt_q;
    logic [4:0]      mul_rd_q;
    logic            mul_rw_q, mul_mr_q, mul_mw_q, w_mul_last, w_mul_done;

    assign w_mul_start = w_accept && in_is_mul;
    assign w_mul_last  = (state_q == S_MUL) && (cnt_q == c_CW'(c_STEPS - 1));
    // The final step waits here until the output slot can take the product.
    assign w_mul_done  = w_mul_last && w_slot_free && !flush;

    always_comb begin
        w_acc_step = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) w_acc_step = w_acc_step + (mcand_q << i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_mul_start) state_d = S_MUL;
            S_MUL:   if (flush || w_mul_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE) && !flush && w_slot_free;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            mcand_q <= '0; mplier_q <= '0; acc_q <= '0; cnt_q <= '0;
            mul_sd_q <= '0; mul_rd_q <= '0;
            mul_rw_q <= 1'b0; mul_mr_q <= 1'b0; mul_mw_q <= 1'b0;
        end else if (w_mul_start) begin
            mcand_q  <= in_rs1;
            mplier_q <= in_rs2;
            acc_q    <= '0;
            cnt_q    <= '0;
            mul_sd_q <= in_rs2;
            mul_rd_q <= in_rd;
            mul_rw_q <= in_reg_write;
            mul_mr_q <= in_mem_read;
            mul_mw_q <= in_mem_write;
        end else if (state_q == S_MUL && !w_mul_last) begin
            acc_q    <= w_acc_step;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q + c_CW'(1);
        end
    end
`else
    logic w_unused_mul;
    assign w_unused_mul = in_is_mul;
    assign w_mul_start  = 1'b0;
    assign in_ready     = !flush && w_slot_free;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0; redirect_valid_q <= 1'b0;
            result_q <= '0; store_q <= '0; redirect_pc_q <= '0; rd_q <= '0;
            rw_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (w_accept && !w_mul_start) begin
                out_valid_q      <= 1'b1;
                result_q         <= w_result;
                store_q          <= in_rs2;
                rd_q             <= in_rd;
                rw_q             <= in_reg_write && !in_is_branch;
                mr_q             <= in_mem_read;
                mw_q             <= in_mem_write;
                redirect_valid_q <= w_redirect;
                redirect_pc_q    <= w_target;
            end
`ifdef EXECUTE_PIPE_MUL_EN
            else if (w_mul_done) begin
                out_valid_q <= 1'b1;
                result_q    <= w_acc_step;
                store_q     <= mul_sd_q;
                rd_q        <= mul_rd_q;
                rw_q        <= mul_rw_q;
                mr_q        <= mul_mr_q;
                mw_q        <= mul_mw_q;
            end
`endif
            else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = result_q;
    assign out_store_data = store_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = rw_q;
    assign out_mem_read   = mr_q;
    assign out_mem_write  = mw_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_execute_pipe                                                 |
// | Brief    : scoreboard bench for execute_pipe (XLEN=32, MUL_STEP=1)         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_execute_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, redirect_valid;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic [31:0] out_result, out_store_data, redirect_pc;
    logic [3:0]  in_alu_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_use_pc = 0, in_use_imm = 0, in_is_branch = 0, in_is_jal = 0, in_is_jalr = 0, in_is_mul = 0;
    logic [4:0]  in_rd = '0, out_rd;
    logic        in_reg_write = 0, in_mem_read = 0, in_mem_write = 0;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        use_pc, use_imm, br, jal, jalr, mul;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } op_t;

    typedef struct {
        logic [31:0] res, sd, rpc;
        logic [4:0]  rd;
        logic        rw, mr, mw, redir;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0, n_bad = 0;
    logic        mon_en = 1'b0, rand_mode = 1'b0, exp_rv = 1'b0;
    logic [31:0] exp_rpc = '0;

    execute_pipe #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
        .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr), .in_is_mul(in_is_mul),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input op_t o);
        exp_t e;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic        tk;
        a = o.use_pc ? o.pc : o.rs1;
        b = o.use_imm ? o.imm : o.rs2;
        sh = b[4:0];
        case (o.alu_op)
            0: e.res = a + b;
            1: e.res = a - b;
            2: e.res = a << sh;
            3: e.res = {31'b0, $signed(a) < $signed(b)};
            4: e.res = {31'b0, a < b};
            5: e.res = a ^ b;
            6: e.res = a >> sh;
            7: e.res = $unsigned($signed(a) >>> sh);
            8: e.res = a | b;
            9: e.res = a & b;
            default: e.res = 32'h0;
        endcase
        case (o.funct3)
            3'b000: tk = o.rs1 == o.rs2;
            3'b001: tk = o.rs1 != o.rs2;
            3'b100: tk = $signed(o.rs1) < $signed(o.rs2);
            3'b101: tk = $signed(o.rs1) >= $signed(o.rs2);
            3'b110: tk = o.rs1 < o.rs2;
            3'b111: tk = o.rs1 >= o.rs2;
            default: tk = 1'b0;
        endcase
        if (o.jal || o.jalr) e.res = o.pc + 32'd4;
`ifdef EXECUTE_PIPE_MUL_EN
        if (o.mul) e.res = o.rs1 * o.rs2;
`endif
        e.sd    = o.rs2;
        e.rd    = o.rd;
        e.rw    = o.rw && !o.br;
        e.mr    = o.mr;
        e.mw    = o.mw;
        e.redir = o.jal || o.jalr || (o.br && tk);
        e.rpc   = o.jalr ? ((o.rs1 + o.imm) & ~32'h1) : o.pc + o.imm;
        return e;
    endfunction

    function automatic op_t mk(input logic [3:0] alu, input logic [31:0] rs1, input logic [31:0] rs2);
        op_t o;
        o = '{pc: 32'h0, rs1: rs1, rs2: rs2, imm: 32'h0, alu_op: alu, funct3: 3'b0,
              use_pc: 0, use_imm: 0, br: 0, jal: 0, jalr: 0, mul: 0, rd: 5'd1, rw: 1, mr: 0, mw: 0};
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        int  k;
        o = mk(4'($urandom_range(0, 15)), $urandom, $urandom);
        if ($urandom_range(0, 3) == 0) o.rs2 = o.rs1;
        o.pc      = $urandom & 32'hFFFF_FFFC;
        o.imm     = $urandom_range(0, 1) ? $urandom : 32'($signed(12'($urandom)));
        o.funct3  = 3'($urandom_range(0, 7));
        o.use_pc  = 1'($urandom_range(0, 1));
        o.use_imm = 1'($urandom_range(0, 1));
        o.rd      = 5'($urandom_range(0, 31));
        o.rw      = 1'($urandom_range(0, 1));
        o.mr      = 1'($urandom_range(0, 1));
        o.mw      = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 15);
        if (k inside {[8:10]}) o.br = 1'b1;
        else if (k == 11 || k == 12) o.jal = 1'b1;
        else if (k == 13 || k == 14) o.jalr = 1'b1;
        else if (k == 15) o.mul = 1'b1;
        return o;
    endfunction

    task automatic apply(input op_t o);
        in_pc = o.pc; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm;
        in_alu_op = o.alu_op; in_funct3 = o.funct3; in_use_pc = o.use_pc; in_use_imm = o.use_imm;
        in_is_branch = o.br; in_is_jal = o.jal; in_is_jalr = o.jalr; in_is_mul = o.mul;
        in_rd = o.rd; in_reg_write = o.rw; in_mem_read = o.mr; in_mem_write = o.mw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
        end
    endtask

    // Holds in_valid until the DUT accepts; returns one tick after the accepting edge.
    task automatic issue(input op_t o);
        logic acc;
        int   n;
        n = 0;
        apply(o);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 300);
        if (!acc) check("issue_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("redir_v", redirect_valid, exp_rv);
            if (exp_rv) check("redir_pc", redirect_pc, exp_rpc);
            exp_rv = 1'b0;
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check("spurious_out", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("res", out_result, e.res);
                        check("sd", out_store_data, e.sd);
                        check("rd", out_rd, e.rd);
                        check("ctl", {out_reg_write, out_mem_read, out_mem_write}, {e.rw, e.mr, e.mw});
                    end
                end
                if (flush) sb.delete();
                if (in_valid && in_ready) begin
                    e = model('{pc: in_pc, rs1: in_rs1, rs2: in_rs2, imm: in_imm, alu_op: in_alu_op,
                                funct3: in_funct3, use_pc: in_use_pc, use_imm: in_use_imm,
                                br: in_is_branch, jal: in_is_jal, jalr: in_is_jalr, mul: in_is_mul,
                                rd: in_rd, rw: in_reg_write, mr: in_mem_read, mw: in_mem_write});
                    sb.push_back(e);
                    exp_rv  = e.redir;
                    exp_rpc = e.rpc;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ov"}, out_valid, 0);
        check({tag, "_rv"}, redirect_valid, 0);
        check({tag, "_res"}, out_result, 0);
        check({tag, "_sd"}, out_store_data, 0);
        check({tag, "_rpc"}, redirect_pc, 0);
        check({tag, "_rd"}, out_rd, 0);
        check({tag, "_ctl"}, {out_reg_write, out_mem_read, out_mem_write}, 0);
        check({tag, "_ir"}, in_ready, 1);
    endtask

    initial begin
        op_t o;
        int  cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("rst");
        mon_en = 1'b1;
        tick();

        issue(mk(4'd0, 32'd5, 32'd7));
        @(negedge clk);
        check("add_ov", out_valid, 1);
        check("add_res", out_result, 32'd12);
        check("add_ir", in_ready, 1);
        tick();

        o = mk(4'd0, 32'd3, 32'd3);
        o.br = 1; o.pc = 32'h100; o.imm = 32'h20;
        issue(o);
        @(negedge clk);
        check("beq_rv", redirect_valid, 1);
        check("beq_rpc", redirect_pc, 32'h120);
        check("beq_rw", out_reg_write, 0);
        tick();
        @(negedge clk);
        check("beq_pulse", redirect_valid, 0);
        tick();
        o.funct3 = 3'b001;
        issue(o);
        @(negedge clk);
        check("bne_rv", redirect_valid, 0);
        tick();

        o = mk(4'd0, 32'h1003, 32'h0);
        o.jalr = 1; o.imm = 32'h4; o.pc = 32'h40;
        issue(o);
        @(negedge clk);
        check("jalr_rv", redirect_valid, 1);
        check("jalr_rpc", redirect_pc, 32'h1006);
        check("jalr_res", out_result, 32'h44);
        tick();

        o = mk(4'd0, 32'hFFFF_FFFF, 32'd3);
        o.mul = 1;
        issue(o);
`ifdef EXECUTE_PIPE_MUL_EN
        cnt = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            tick();
        end
        check("mul_busy", cnt, 32);
        check("mul_res", out_result, 32'hFFFF_FFFD);
`else
        cnt = 0;
        @(negedge clk);
        check("mul_as_alu", out_result, 32'h2);
        check("mul_lat1", out_valid, 1);
`endif
        tick();

        repeat (3) tick();
        out_ready = 1'b0;
        issue(mk(4'd0, 32'd9, 32'd4));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("hold_ov", out_valid, 1);
            check("hold_res", out_result, 32'd13);
            check("hold_ir", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("hold_drop", out_valid, 0);
        tick();

        o = mk(4'd0, 32'h1234, 32'h55);
        o.mul = 1;
        issue(o);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (40) tick();
        @(negedge clk);
        check("flush_ov", out_valid, 0);
        check("flush_ir", in_ready, 1);
        tick();

        o.rs1 = 32'hABCD;
        issue(o);
        repeat (5) tick();
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        check_reset_state("mrst");
        repeat (40) tick();

        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) issue(rnd_op());
        rand_mode = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        repeat (80) tick();
        check("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter MUL_STEP, default 1, multiplier bits retired per cycle; MUL_STEP SHALL divide XLEN.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 flush  input  1  kill in-flight and held operations.
REQ-006 in_valid / in_ready  input / output  1 each  upstream handshake.
REQ-007 in_pc, in_rs1, in_rs2, in_imm  input  XLEN each  operands, imm already sign-extended.
REQ-008 in_alu_op  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, others produce 0.
REQ-009 in_funct3  input  3  branch condition: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, others never taken.
REQ-010 in_use_pc, in_use_imm, in_is_branch, in_is_jal, in_is_jalr, in_is_mul  input  1 each  operation select.
REQ-011 in_rd  input  5; in_reg_write, in_mem_read, in_mem_write  input  1 each  control passed through.
REQ-012 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-013 out_result, out_store_data  output  XLEN each; out_rd output 5; out_reg_write, out_mem_read, out_mem_write output 1 each.
REQ-014 redirect_valid  output  1; redirect_pc  output  XLEN  fetch redirect.

Function
REQ-015 Operand A SHALL be in_pc when in_use_pc else in_rs1; operand B SHALL be in_imm when in_use_imm else in_rs2; shift amount SHALL be B[log2(XLEN)-1:0]; all arithmetic modulo 2^XLEN.
REQ-016 States: IDLE, MUL. in_ready SHALL equal (state==IDLE) && !flush && (!out_valid || out_ready).
REQ-017 Accept occurs when in_valid && in_ready; non-MUL ops SHALL present results with out_valid=1 on the cycle after acceptance (latency 1).
REQ-018 out_* SHALL hold stable while out_valid && !out_ready; out_valid SHALL clear after an out_ready handshake with no new result loaded.
REQ-019 jal/jalr: out_result SHALL be in_pc+4; redirect_pc SHALL be in_pc+in_imm (jal) or (in_rs1+in_imm) with bit 0 cleared (jalr).
REQ-020 Branch: comparison on in_rs1 vs in_rs2 per in_funct3; taken SHALL give redirect_pc = in_pc+in_imm; out_reg_write SHALL be 0 for branches.
REQ-021 redirect_valid SHALL pulse exactly one cycle, the cycle after acceptance of a taken branch, jal or jalr; never otherwise.
REQ-022 out_store_data SHALL be in_rs2 of the accepted op.
REQ-023 MUL (in_is_mul): IDLE->MUL on accept; shift-add, MUL_STEP bits/cycle, XLEN/MUL_STEP cycles; MUL->IDLE on final step with out_valid=1 next cycle; out_result = low XLEN bits of in_rs1*in_rs2.
REQ-024 A MUL completing while out_valid && !out_ready SHALL stall in MUL on its final step until the output slot frees.
REQ-025 flush SHALL, at the next edge, clear out_valid and redirect_valid, abort MUL to IDLE, discard partial product; no input accepted in the flush cycle.
REQ-026 flush and a same-cycle redirect_valid: redirect_valid stays asserted that cycle; flush only suppresses later pulses.

Reset
REQ-027 rst_n low at posedge clk: state IDLE, out_valid 0, redirect_valid 0, out_reg_write/out_mem_read/out_mem_write 0, out_result/out_store_data/redirect_pc 0, out_rd 0.
REQ-028 Reset mid-MUL SHALL abandon the operation with no output produced; reset dominates flush.

Configuration
REQ-029 Macro EXECUTE_PIPE_MUL_EN defined: REQ-023/024 MUL path present.
REQ-030 Macro undefined: no MUL state or multiplier logic; in_is_mul ignored and the op executes as an ordinary ALU op with latency 1.

Verification
REQ-031 XLEN=32, ADD rs1=5 rs2=7, out_ready=1 -> next cycle out_valid=1, out_result=12, in_ready stays 1.
REQ-032 BEQ rs1=rs2=3, pc=0x100, imm=0x20 -> one-cycle redirect_valid, redirect_pc=0x120, out_reg_write=0; BNE same operands -> no redirect.
REQ-033 JALR rs1=0x1003, imm=0x4, pc=0x40 -> redirect_pc=0x1006, out_result=0x44.
REQ-034 MUL_EN, MUL_STEP=1, rs1=0xFFFFFFFF rs2=3 -> in_ready=0 for 32 cycles, then out_result=0xFFFFFFFD.
REQ-035 Result held with out_ready=0 for 5 cycles -> out_* stable, in_ready=0; out_ready=1 -> handshake, out_valid drops.
REQ-036 flush at MUL cycle 10, then rst_n low during a second MUL -> no output in either case; IDLE, all outputs per REQ-027.
